// File: rtl/fan_ctrl_pkg.sv
// Shared types, constants and the level-to-speed mapping for the fan controller.
package fan_ctrl_pkg;

    localparam int unsigned TEMP_W  = 7;
    localparam int unsigned SUM_W   = 9;
    localparam int unsigned ERR_W   = 8;
    localparam int unsigned WIN_LEN = 4;
    localparam int unsigned FILL_W  = 3;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRIVE = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    typedef logic [1:0] level_t;

    localparam level_t LEVEL_SLOW = 2'd1;
    localparam level_t LEVEL_MED  = 2'd2;
    localparam level_t LEVEL_FAST = 2'd3;

    localparam logic [1:0] SPEED_OFF  = 2'd0;
    localparam logic [1:0] SPEED_ONE  = 2'd1;
    localparam logic [1:0] SPEED_TWO  = 2'd2;
    localparam logic [1:0] SPEED_THREE = 2'd3;

    // Registered controller outputs as one payload.
    typedef struct packed {
        logic [1:0] fan_speed;
        logic       sign;
        logic       at_target;
        logic       fault;
    } ctrl_out_t;

    localparam ctrl_out_t OUT_OFF   = '{fan_speed: SPEED_OFF, sign: 1'b0, at_target: 1'b0, fault: 1'b0};
    localparam ctrl_out_t OUT_HOLD  = '{fan_speed: SPEED_OFF, sign: 1'b0, at_target: 1'b1, fault: 1'b0};
    localparam ctrl_out_t OUT_FAULT = '{fan_speed: SPEED_OFF, sign: 1'b0, at_target: 1'b0, fault: 1'b1};

    // The plant's heating path divides faster, so heating codes run inverted.
    function automatic logic [1:0] map_speed(input logic sign, input level_t level);
        logic [1:0] code;
        code = SPEED_OFF;
        if (!sign) begin
            code = level;
        end else begin
            case (level)
                LEVEL_FAST: code = SPEED_ONE;
                LEVEL_MED:  code = SPEED_TWO;
                LEVEL_SLOW: code = SPEED_THREE;
                default:    code = SPEED_OFF;
            endcase
        end
        return code;
    endfunction

endpackage

// File: rtl/fan_speed_controller_if.sv
// Control/status bundle between the fan controller and its environment.
interface fan_speed_controller_if;
    import fan_ctrl_pkg::*;

    logic              enable;
    logic              temp_update;
    logic [TEMP_W-1:0] temperature;
    logic [TEMP_W-1:0] setpoint;
    logic [1:0]        fan_speed;
    logic              sign;
    logic              at_target;
    logic              fault;

    modport master (
        output enable, temp_update, temperature, setpoint,
        input  fan_speed, sign, at_target, fault
    );

    modport slave (
        input  enable, temp_update, temperature, setpoint,
        output fan_speed, sign, at_target, fault
    );

endinterface

// File: rtl/temp_avg4.sv
// Four-sample moving average of the plant temperature.
module temp_avg4
    import fan_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              temp_update,
    input  logic [TEMP_W-1:0] temperature,
    output logic [TEMP_W-1:0] avg_c,
    output logic              avg_valid_c
);

    logic [TEMP_W-1:0] window_q [WIN_LEN];
    logic [FILL_W-1:0] fill_q;
    logic [SUM_W-1:0]  sum_c;

    // Shift new samples in; a disabled controller keeps its history.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(WIN_LEN); i++) begin
                window_q[i] <= '0;
            end
            fill_q <= '0;
        end else if (enable && temp_update) begin
            window_q[0] <= temperature;
            for (int i = 1; i < int'(WIN_LEN); i++) begin
                window_q[i] <= window_q[i-1];
            end
            if (fill_q != FILL_W'(WIN_LEN)) begin
                fill_q <= fill_q + FILL_W'(1);
            end
        end
    end

    // Truncating average of the window.
    always_comb begin
        sum_c = SUM_W'(window_q[0]) + SUM_W'(window_q[1])
              + SUM_W'(window_q[2]) + SUM_W'(window_q[3]);
        avg_c       = TEMP_W'(sum_c >> 2);
        avg_valid_c = (fill_q == FILL_W'(WIN_LEN));
    end

endmodule

// File: rtl/fan_speed_controller.sv
// Closed-loop fan controller: filtered error, deadband/hysteresis, dwell and stall protection.
module fan_speed_controller
    import fan_ctrl_pkg::*;
#(
    parameter int unsigned DEADBAND    = 1,
    parameter int unsigned HYST        = 2,
    parameter int unsigned MED_BAND    = 8,
    parameter int unsigned HIGH_BAND   = 20,
    parameter int unsigned MIN_DWELL   = 4,
    parameter int unsigned STALL_LIMIT = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    fan_speed_controller_if.slave  bus
);

    localparam int unsigned DWELL_W = $clog2(MIN_DWELL + 1);
    localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);

    logic [TEMP_W-1:0]       avg_c;
    logic                    avg_valid_c;
    logic [TEMP_W-1:0]       setpoint_q;
    logic                    upd_q;

    logic signed [ERR_W-1:0] err_c;
    logic [TEMP_W-1:0]       mag_c;
    level_t                  level_c;
    logic                    want_sign_c;
    logic [1:0]              want_speed_c;
    ctrl_out_t               drive_out_c;
    logic                    drive_change_c;

    logic [DWELL_W-1:0]      dwell_inc_c;
    logic                    dwell_expired_c;
    logic [STALL_W-1:0]      stall_inc_c;
    logic                    stall_trip_c;

    state_t                  state_q, state_n;
    ctrl_out_t               out_q, out_n;
    logic [DWELL_W-1:0]      dwell_q, dwell_n;
    logic [STALL_W-1:0]      stall_q, stall_n;
    logic [TEMP_W-1:0]       prev_mag_q, prev_mag_n;

    temp_avg4 u_avg (
        .clk         (CLK),
        .rst         (RST),
        .enable      (bus.enable),
        .temp_update (bus.temp_update),
        .temperature (bus.temperature),
        .avg_c       (avg_c),
        .avg_valid_c (avg_valid_c)
    );

    // Capture the setpoint with each sample and delay the pulse to line up with the window.
    always_ff @(posedge CLK) begin
        if (RST) begin
            setpoint_q <= '0;
            upd_q      <= 1'b0;
        end else if (!bus.enable) begin
            upd_q      <= 1'b0;
        end else begin
            upd_q <= bus.temp_update;
            if (bus.temp_update) begin
                setpoint_q <= bus.setpoint;
            end
        end
    end

    // Signed error, its magnitude and the requested drive level.
    always_comb begin
        err_c = $signed({1'b0, avg_c}) - $signed({1'b0, setpoint_q});
        mag_c = err_c[ERR_W-1] ? TEMP_W'(-err_c) : err_c[TEMP_W-1:0];
        if (mag_c > TEMP_W'(HIGH_BAND)) begin
            level_c = LEVEL_FAST;
        end else if (mag_c > TEMP_W'(MED_BAND)) begin
            level_c = LEVEL_MED;
        end else begin
            level_c = LEVEL_SLOW;
        end
        want_sign_c    = err_c[ERR_W-1];
        want_speed_c   = map_speed(want_sign_c, level_c);
        drive_out_c    = '{fan_speed: want_speed_c, sign: want_sign_c, at_target: 1'b0, fault: 1'b0};
        drive_change_c = ({want_speed_c, want_sign_c} != {out_q.fan_speed, out_q.sign});
    end

    // Saturating dwell and stall counts as they would stand after this update.
    always_comb begin
        dwell_inc_c = (dwell_q == DWELL_W'(MIN_DWELL)) ? dwell_q : dwell_q + DWELL_W'(1);
        dwell_expired_c = (dwell_inc_c == DWELL_W'(MIN_DWELL));
        if (mag_c >= prev_mag_q) begin
            stall_inc_c = (stall_q == STALL_W'(STALL_LIMIT)) ? stall_q : stall_q + STALL_W'(1);
        end else begin
            stall_inc_c = '0;
        end
        stall_trip_c = (stall_inc_c == STALL_W'(STALL_LIMIT));
    end

    // State, output and counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_INIT;
            out_q      <= OUT_OFF;
            dwell_q    <= '0;
            stall_q    <= '0;
            prev_mag_q <= '0;
        end else begin
            state_q    <= state_n;
            out_q      <= out_n;
            dwell_q    <= dwell_n;
            stall_q    <= stall_n;
            prev_mag_q <= prev_mag_n;
        end
    end

    // Next-state and output decision, evaluated once per filtered sample.
    always_comb begin
        state_n    = state_q;
        out_n      = out_q;
        dwell_n    = dwell_q;
        stall_n    = stall_q;
        prev_mag_n = prev_mag_q;

        if (!bus.enable) begin
            state_n    = ST_INIT;
            out_n      = OUT_OFF;
            dwell_n    = '0;
            stall_n    = '0;
            prev_mag_n = '0;
        end else if (upd_q) begin
            prev_mag_n = mag_c;
            case (state_q)
                ST_INIT: begin
                    if (avg_valid_c) begin
                        stall_n = '0;
                        if (mag_c <= TEMP_W'(DEADBAND)) begin
                            // Outputs stay off, so the next decision need not wait.
                            state_n = ST_HOLD;
                            out_n   = OUT_HOLD;
                            dwell_n = DWELL_W'(MIN_DWELL);
                        end else begin
                            state_n = ST_DRIVE;
                            out_n   = drive_out_c;
                            dwell_n = '0;
                        end
                    end
                end
                ST_HOLD: begin
                    dwell_n = dwell_inc_c;
                    if (mag_c > TEMP_W'(DEADBAND + HYST) && dwell_expired_c) begin
                        state_n = ST_DRIVE;
                        out_n   = drive_out_c;
                        dwell_n = '0;
                        stall_n = '0;
                    end
                end
                ST_DRIVE: begin
                    dwell_n = dwell_inc_c;
                    stall_n = stall_inc_c;
                    if (stall_trip_c) begin
                        state_n = ST_FAULT;
                        out_n   = OUT_FAULT;
                        dwell_n = '0;
                        stall_n = '0;
                    end else if (mag_c <= TEMP_W'(DEADBAND)) begin
                        if (dwell_expired_c) begin
                            state_n = ST_HOLD;
                            out_n   = OUT_HOLD;
                            dwell_n = '0;
                            stall_n = '0;
                        end
                    end else if (drive_change_c && dwell_expired_c) begin
                        out_n   = drive_out_c;
                        dwell_n = '0;
                    end
                end
                ST_FAULT: begin
                    out_n = OUT_FAULT;
                end
                default: begin
                    state_n = ST_INIT;
                    out_n   = OUT_OFF;
                end
            endcase
        end
    end

    assign bus.fan_speed = out_q.fan_speed;
    assign bus.sign      = out_q.sign;
    assign bus.at_target = out_q.at_target;
    assign bus.fault     = out_q.fault;

endmodule

// File: tb/tb_fan_speed_controller.sv
// Directed bench for fan_speed_controller; outputs checked as {fan_speed, sign, at_target, fault}.
module tb_fan_speed_controller;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    fan_speed_controller_if bus ();

    fan_speed_controller dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    logic [4:0] outs;
    assign outs = {bus.fan_speed, bus.sign, bus.at_target, bus.fault};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst             = 1'b1;
        bus.enable      = 1'b1;
        bus.temp_update = 1'b0;
        bus.temperature = '0;
        bus.setpoint    = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One update pulse; returns two edges later when the decision is visible.
    task automatic send(input logic [6:0] temp, input logic [6:0] sp);
        bus.temperature = temp;
        bus.setpoint    = sp;
        bus.temp_update = 1'b1;
        @(negedge clk);
        bus.temp_update = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (outs !== 5'b00000) begin
            miscompares++;
            $display("FAIL reset: outs=%b expected %b", outs, 5'b00000);
        end
    endtask

    task automatic test_cool_to_hold();
        logic [4:0] exp_v [4];
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(7'd80, 7'd50);
            vectors++;
            if (outs !== 5'b00000) begin
                miscompares++;
                $display("FAIL cool_fill[%0d]: outs=%b expected %b", i, outs, 5'b00000);
            end
        end
        bus.temperature = 7'd80;
        bus.temp_update = 1'b1;
        @(negedge clk);
        bus.temp_update = 1'b0;
        vectors++;
        if (outs !== 5'b00000) begin
            miscompares++;
            $display("FAIL cool_latency_n1: outs=%b expected %b", outs, 5'b00000);
        end
        @(negedge clk);
        vectors++;
        if (outs !== 5'b11000) begin
            miscompares++;
            $display("FAIL cool_latency_n2: outs=%b expected %b", outs, 5'b11000);
        end
        exp_v = '{5'b11000, 5'b11000, 5'b11000, 5'b00010};
        for (int i = 0; i < 4; i++) begin
            send(7'd50, 7'd50);
            vectors++;
            if (outs !== exp_v[i]) begin
                miscompares++;
                $display("FAIL cool_settle[%0d]: outs=%b expected %b", i, outs, exp_v[i]);
            end
        end
    endtask

    task automatic test_heat();
        logic [4:0] exp_v [4];
        do_reset();
        for (int i = 0; i < 4; i++) send(7'd50, 7'd60);
        vectors++;
        if (outs !== 5'b10100) begin
            miscompares++;
            $display("FAIL heat_start: outs=%b expected %b", outs, 5'b10100);
        end
        exp_v = '{5'b10100, 5'b10100, 5'b10100, 5'b01100};
        for (int i = 0; i < 4; i++) begin
            send(7'd35, 7'd60);
            vectors++;
            if (outs !== exp_v[i]) begin
                miscompares++;
                $display("FAIL heat_fast[%0d]: outs=%b expected %b", i, outs, exp_v[i]);
            end
        end
    endtask

    task automatic test_hysteresis();
        logic [4:0] exp_v [4];
        do_reset();
        for (int i = 0; i < 4; i++) send(7'd50, 7'd50);
        vectors++;
        if (outs !== 5'b00010) begin
            miscompares++;
            $display("FAIL hyst_hold: outs=%b expected %b", outs, 5'b00010);
        end
        for (int i = 0; i < 4; i++) begin
            send(7'd52, 7'd50);
            vectors++;
            if (outs !== 5'b00010) begin
                miscompares++;
                $display("FAIL hyst_inside[%0d]: outs=%b expected %b", i, outs, 5'b00010);
            end
        end
        exp_v = '{5'b00010, 5'b00010, 5'b00010, 5'b01000};
        for (int i = 0; i < 4; i++) begin
            send(7'd54, 7'd50);
            vectors++;
            if (outs !== exp_v[i]) begin
                miscompares++;
                $display("FAIL hyst_leave[%0d]: outs=%b expected %b", i, outs, exp_v[i]);
            end
        end
    endtask

    task automatic test_stall_fault();
        logic [4:0] exp;
        do_reset();
        for (int i = 0; i < 4; i++) send(7'd80, 7'd50);
        vectors++;
        if (outs !== 5'b11000) begin
            miscompares++;
            $display("FAIL stall_start: outs=%b expected %b", outs, 5'b11000);
        end
        for (int i = 1; i <= 16; i++) begin
            send(7'd80, 7'd50);
            exp = (i == 16) ? 5'b00001 : 5'b11000;
            vectors++;
            if (outs !== exp) begin
                miscompares++;
                $display("FAIL stall_count[%0d]: outs=%b expected %b", i, outs, exp);
            end
        end
        bus.enable = 1'b0;
        @(negedge clk);
        bus.enable = 1'b1;
        vectors++;
        if (outs !== 5'b00000) begin
            miscompares++;
            $display("FAIL stall_disable: outs=%b expected %b", outs, 5'b00000);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (outs !== 5'b00000) begin
            miscompares++;
            $display("FAIL stall_idle: outs=%b expected %b", outs, 5'b00000);
        end
        send(7'd80, 7'd50);
        vectors++;
        if (outs !== 5'b11000) begin
            miscompares++;
            $display("FAIL stall_resume: outs=%b expected %b", outs, 5'b11000);
        end
    endtask

    task automatic test_dwell();
        logic [1:0] exp_fan [10];
        do_reset();
        for (int i = 0; i < 4; i++) send(7'd70, 7'd60);
        vectors++;
        if (outs !== 5'b10000) begin
            miscompares++;
            $display("FAIL dwell_start: outs=%b expected %b", outs, 5'b10000);
        end
        exp_fan = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
        for (int i = 0; i < 10; i++) begin
            send(7'd70, (i % 2 == 0) ? 7'd64 : 7'd60);
            vectors++;
            if (outs !== {exp_fan[i], 3'b000}) begin
                miscompares++;
                $display("FAIL dwell_alt[%0d]: outs=%b expected %b", i, outs, {exp_fan[i], 3'b000});
            end
        end
    endtask

    task automatic test_reset_mid_drive();
        do_reset();
        for (int i = 0; i < 4; i++) send(7'd80, 7'd50);
        vectors++;
        if (outs !== 5'b11000) begin
            miscompares++;
            $display("FAIL rstmid_drive: outs=%b expected %b", outs, 5'b11000);
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (outs !== 5'b00000) begin
            miscompares++;
            $display("FAIL rstmid_clear: outs=%b expected %b", outs, 5'b00000);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(7'd80, 7'd50);
            vectors++;
            if (outs !== 5'b00000) begin
                miscompares++;
                $display("FAIL rstmid_refill[%0d]: outs=%b expected %b", i, outs, 5'b00000);
            end
        end
        send(7'd80, 7'd50);
        vectors++;
        if (outs !== 5'b11000) begin
            miscompares++;
            $display("FAIL rstmid_restart: outs=%b expected %b", outs, 5'b11000);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_cool_to_hold();
        test_heat();
        test_hysteresis();
        test_stall_fault();
        test_dwell();
        test_reset_mid_drive();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
